// File: rtl/synth_kbd_pkg.sv
// synth_kbd_pkg: PS/2 set-2 scan codes, decoder FSM states and key tables
// shared by the synth keyboard decoder.
package synth_kbd_pkg;

   localparam logic [7:0] SC_EXT     = 8'hE0;
   localparam logic [7:0] SC_BRK     = 8'hF0;
   localparam logic [7:0] SC_OCT_UP  = 8'h22;
   localparam logic [7:0] SC_OCT_DN  = 8'h1A;
   localparam logic [7:0] SC_ADSR_UP = 8'h55;
   localparam logic [7:0] SC_ADSR_DN = 8'h4E;

   localparam int NOTE_MAX = 12;
   localparam int ADSR_MAX = 4;

   localparam logic [7:0] NOTE_CODES [NOTE_MAX+1] = '{
      8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C,
      8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B, 8'h42
   };

   localparam logic [7:0] ADSR_CODES [ADSR_MAX+1] = '{
      8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E
   };

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BRK     = 2'd1,
      EXT     = 2'd2,
      EXT_BRK = 2'd3
   } kbd_state_t;

   typedef struct packed {
      logic       hit;
      logic [2:0] sel;
   } adsr_hit_t;

   function automatic adsr_hit_t adsr_lookup(input logic [7:0] code);
      adsr_hit_t r;
      r = '0;
      for (int i = 0; i <= ADSR_MAX; i++) begin
         if (code == ADSR_CODES[i]) r = '{hit: 1'b1, sel: 3'(i)};
      end
      return r;
   endfunction

endpackage

// File: rtl/ps2_note_map.sv
// ps2_note_map: combinational lookup of a scan code into one of the thirteen note keys.
module ps2_note_map
   import synth_kbd_pkg::*;
(
   input  logic [7:0] code,
   output logic       hit,
   output logic [3:0] note
);

   always_comb begin
      hit  = 1'b0;
      note = '0;
      for (int i = 0; i <= NOTE_MAX; i++) begin
         if (code == NOTE_CODES[i]) begin
            hit  = 1'b1;
            note = 4'(i);
         end
      end
   end

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: turns a stream of PS/2 set-2 bytes into held-key levels for the synth
// (note, octave +/-, ADSR parameter select and +/-), with a watchdog on dangling prefixes.
module ps2_key_decoder
   import synth_kbd_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 2500000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       byte_valid,
   input  logic [7:0] byte_data,
   output logic       note_in,
   output logic [3:0] note,
   output logic       octave_plus_plus,
   output logic       octave_minus_minus,
   output logic [2:0] ADSR_selector,
   output logic       ADSR_plus_plus,
   output logic       ADSR_minus_minus
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   kbd_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          note_in_q, note_in_d;
   logic [3:0]    note_q, note_d;
   logic          oct_up_q, oct_up_d;
   logic          oct_dn_q, oct_dn_d;
   logic [2:0]    sel_q, sel_d;
   logic          adsr_up_q, adsr_up_d;
   logic          adsr_dn_q, adsr_dn_d;

   logic          map_hit;
   logic [3:0]    map_note;
   adsr_hit_t     adsr;
   logic          make, brk, timeout, key_evt;

   ps2_note_map u_note_map (
      .code (byte_data),
      .hit  (map_hit),
      .note (map_note)
   );

   assign adsr    = adsr_lookup(byte_data);
   assign make    = byte_valid && state_q == IDLE && byte_data != SC_BRK && byte_data != SC_EXT;
   assign brk     = byte_valid && state_q == BRK;
   assign key_evt = make || brk;
   // The last idle cycle of the window expires the prefix; a byte in that cycle still wins.
   assign timeout = !byte_valid && state_q != IDLE && cnt_q == CW'(TIMEOUT_CYCLES - 1);

   always_comb begin
      state_d = !byte_valid ? (timeout ? IDLE : state_q)
              : state_q == IDLE ? (byte_data == SC_BRK ? BRK : byte_data == SC_EXT ? EXT : IDLE)
              : (state_q == EXT && byte_data == SC_BRK) ? EXT_BRK : IDLE;
      cnt_d     = (byte_valid || state_q == IDLE || timeout) ? '0 : cnt_q + CW'(1);
      note_d    = (make && map_hit) ? map_note : note_q;
      note_in_d = (make && map_hit) ? 1'b1
                : (brk && map_hit && map_note == note_q) ? 1'b0 : note_in_q;
      oct_up_d  = (key_evt && byte_data == SC_OCT_UP)  ? make : oct_up_q;
      oct_dn_d  = (key_evt && byte_data == SC_OCT_DN)  ? make : oct_dn_q;
      adsr_up_d = (key_evt && byte_data == SC_ADSR_UP) ? make : adsr_up_q;
      adsr_dn_d = (key_evt && byte_data == SC_ADSR_DN) ? make : adsr_dn_q;
      sel_d     = (make && adsr.hit) ? adsr.sel : sel_q;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         note_in_q <= 1'b0;
         note_q    <= '0;
         oct_up_q  <= 1'b0;
         oct_dn_q  <= 1'b0;
         sel_q     <= '0;
         adsr_up_q <= 1'b0;
         adsr_dn_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         note_in_q <= note_in_d;
         note_q    <= note_d;
         oct_up_q  <= oct_up_d;
         oct_dn_q  <= oct_dn_d;
         sel_q     <= sel_d;
         adsr_up_q <= adsr_up_d;
         adsr_dn_q <= adsr_dn_d;
      end
   end

   assign note_in            = note_in_q;
   assign note               = note_q;
   assign octave_plus_plus   = oct_up_q;
   assign octave_minus_minus = oct_dn_q;
   assign ADSR_selector      = sel_q;
   assign ADSR_plus_plus     = adsr_up_q;
   assign ADSR_minus_minus   = adsr_dn_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed scan-code sequences, checked every cycle against a
// keyboard-level model of held keys plus literal expectations at key points.
module tb_ps2_key_decoder;

   localparam int T = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       byte_valid = 1'b0;
   logic [7:0] byte_data = 8'h00;
   logic       note_in, oct_up, oct_dn, adsr_up, adsr_dn;
   logic [3:0] note;
   logic [2:0] sel;

   int total = 0;
   int bad = 0;
   bit chk_en = 1'b0;

   logic [7:0] note_keys [13] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C,
                                  8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B, 8'h42};
   logic [7:0] sel_keys [5] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};

   logic [7:0] pend [$];
   int         quiet = 0;
   logic       m_note_in, m_oct_up, m_oct_dn, m_adsr_up, m_adsr_dn;
   logic [3:0] m_note;
   logic [2:0] m_sel;

   ps2_key_decoder #(.TIMEOUT_CYCLES(T)) dut (
      .clk                (clk),
      .reset              (reset),
      .byte_valid         (byte_valid),
      .byte_data          (byte_data),
      .note_in            (note_in),
      .note               (note),
      .octave_plus_plus   (oct_up),
      .octave_minus_minus (oct_dn),
      .ADSR_selector      (sel),
      .ADSR_plus_plus     (adsr_up),
      .ADSR_minus_minus   (adsr_dn)
   );

   always #10 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic int find_key(input logic [7:0] b, input bit is_note);
      if (is_note) begin
         for (int i = 0; i < 13; i++) if (note_keys[i] == b) return i;
      end else begin
         for (int i = 0; i < 5; i++) if (sel_keys[i] == b) return i;
      end
      return -1;
   endfunction

   task automatic key_event(input logic [7:0] b, input bit mk);
      int n, s;
      n = find_key(b, 1'b1);
      s = find_key(b, 1'b0);
      if (n >= 0) begin
         if (mk) begin
            m_note = 4'(n);
            m_note_in = 1'b1;
         end else if (n == int'(m_note)) m_note_in = 1'b0;
      end
      if (mk && s >= 0) m_sel = 3'(s);
      if (b == 8'h22) m_oct_up = mk;
      if (b == 8'h1A) m_oct_dn = mk;
      if (b == 8'h55) m_adsr_up = mk;
      if (b == 8'h4E) m_adsr_dn = mk;
   endtask

   always @(posedge clk) begin
      if (!reset) begin
         pend.delete();
         quiet = 0;
         {m_note_in, m_oct_up, m_oct_dn, m_adsr_up, m_adsr_dn} = '0;
         m_note = '0;
         m_sel = '0;
      end else if (byte_valid) begin
         quiet = 0;
         if (pend.size() == 0 && (byte_data == 8'hF0 || byte_data == 8'hE0)) pend.push_back(byte_data);
         else if (pend.size() == 0) key_event(byte_data, 1'b1);
         else if (pend.size() == 1 && pend[0] == 8'hE0 && byte_data == 8'hF0) pend.push_back(byte_data);
         else begin
            if (pend[0] == 8'hF0) key_event(byte_data, 1'b0);
            pend.delete();
         end
      end else if (pend.size() > 0) begin
         quiet++;
         if (quiet >= T) begin
            pend.delete();
            quiet = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_note_in", {7'd0, note_in}, {7'd0, m_note_in});
         chk("model_note", {4'd0, note}, {4'd0, m_note});
         chk("model_oct_up", {7'd0, oct_up}, {7'd0, m_oct_up});
         chk("model_oct_dn", {7'd0, oct_dn}, {7'd0, m_oct_dn});
         chk("model_sel", {5'd0, sel}, {5'd0, m_sel});
         chk("model_adsr_up", {7'd0, adsr_up}, {7'd0, m_adsr_up});
         chk("model_adsr_dn", {7'd0, adsr_dn}, {7'd0, m_adsr_dn});
      end
   end

   task automatic send(input logic [7:0] b);
      @(posedge clk);
      #1 byte_valid = 1'b1;
      byte_data = b;
      @(posedge clk);
      #1 byte_valid = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 chk_en = 1'b1;
      @(negedge clk);
      chk("rst_note_in", {7'd0, note_in}, 8'd0);
      chk("rst_note", {4'd0, note}, 8'd0);
      chk("rst_oct_up", {7'd0, oct_up}, 8'd0);
      chk("rst_oct_dn", {7'd0, oct_dn}, 8'd0);
      chk("rst_sel", {5'd0, sel}, 8'd0);
      chk("rst_adsr_up", {7'd0, adsr_up}, 8'd0);
      chk("rst_adsr_dn", {7'd0, adsr_dn}, 8'd0);
      reset = 1'b1;

      send(8'h1C);
      @(negedge clk);
      chk("a_make_note", {4'd0, note}, 8'd0);
      chk("a_make_in", {7'd0, note_in}, 8'd1);
      send(8'hF0); send(8'h1C);
      @(negedge clk);
      chk("a_break_in", {7'd0, note_in}, 8'd0);

      send(8'h1C); send(8'h42);
      @(negedge clk);
      chk("k_over_a_note", {4'd0, note}, 8'd12);
      send(8'hF0); send(8'h1C);
      @(negedge clk);
      chk("stale_break_in", {7'd0, note_in}, 8'd1);
      chk("stale_break_note", {4'd0, note}, 8'd12);
      send(8'hF0); send(8'h42);
      @(negedge clk);
      chk("k_break_in", {7'd0, note_in}, 8'd0);

      for (int i = 0; i < 3; i++) begin
         send(8'h22);
         @(negedge clk);
         chk("x_repeat", {7'd0, oct_up}, 8'd1);
      end
      send(8'h1A);
      @(negedge clk);
      chk("xz_both_dn", {7'd0, oct_dn}, 8'd1);
      chk("xz_both_up", {7'd0, oct_up}, 8'd1);
      send(8'hF0); send(8'h22);
      @(negedge clk);
      chk("x_break", {7'd0, oct_up}, 8'd0);
      send(8'hF0); send(8'h1A);

      send(8'h26); send(8'h55);
      @(negedge clk);
      chk("sel_2", {5'd0, sel}, 8'd2);
      chk("adsr_up_held", {7'd0, adsr_up}, 8'd1);
      send(8'hF0); send(8'h55);
      @(negedge clk);
      chk("adsr_up_break", {7'd0, adsr_up}, 8'd0);
      send(8'h4E); send(8'h2E); send(8'hF0); send(8'h2E);
      @(negedge clk);
      chk("sel_4_held", {5'd0, sel}, 8'd4);
      chk("adsr_dn_held", {7'd0, adsr_dn}, 8'd1);
      send(8'hF0); send(8'h4E);
      send(8'h76); send(8'hF0); send(8'h76); send(8'hE0); send(8'h76);
      @(negedge clk);
      chk("unmapped_sel", {5'd0, sel}, 8'd4);
      chk("unmapped_in", {7'd0, note_in}, 8'd0);

      for (int i = 0; i < 13; i++) begin
         send(note_keys[i]);
         @(negedge clk);
         chk("note_sweep", {4'd0, note}, 8'(i));
      end
      send(8'hF0); send(8'h42);

      send(8'hF0);
      repeat (T - 1) @(posedge clk);
      send(8'h1C);
      @(negedge clk);
      chk("timeout_make_in", {7'd0, note_in}, 8'd1);
      send(8'hF0);
      repeat (T - 2) @(posedge clk);
      send(8'h1C);
      @(negedge clk);
      chk("in_window_break", {7'd0, note_in}, 8'd0);

      send(8'h1C); send(8'hE0); send(8'hF0); send(8'h1C);
      @(negedge clk);
      chk("ext_break_ign", {7'd0, note_in}, 8'd1);
      send(8'hE0); send(8'h42);
      @(negedge clk);
      chk("ext_make_ign", {4'd0, note}, 8'd0);

      send(8'hF0);
      @(posedge clk);
      #1 reset = 1'b0;
      byte_valid = 1'b1;
      byte_data = 8'h1C;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      byte_valid = 1'b0;
      @(negedge clk);
      chk("mid_reset_in", {7'd0, note_in}, 8'd0);
      send(8'h1C);
      @(negedge clk);
      chk("post_reset_make", {7'd0, note_in}, 8'd1);

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 2500000, max clocks allowed between a prefix byte (E0/F0) and its following byte.
REQ-002 SHALL have port clk  in  1  system clock (50 MHz).
REQ-003 SHALL have port reset  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port byte_valid  in  1  one-cycle strobe marking a received PS/2 set-2 byte.
REQ-005 SHALL have port byte_data  in  8  received scan-code byte, valid only with byte_valid.
REQ-006 SHALL have port note_in  out  1  high while a note key is held.
REQ-007 SHALL have port note  out  4  index of the held note, 0..12.
REQ-008 SHALL have port octave_plus_plus  out  1  high while key X (22) is held.
REQ-009 SHALL have port octave_minus_minus  out  1  high while key Z (1A) is held.
REQ-010 SHALL have port ADSR_selector  out  3  last selected parameter, 0..4.
REQ-011 SHALL have port ADSR_plus_plus  out  1  high while key '=' (55) is held.
REQ-012 SHALL have port ADSR_minus_minus  out  1  high while key '-' (4E) is held.

Function
REQ-013 SHALL map note keys A,W,S,E,D,F,T,G,Y,H,U,J,K (1C,1D,1B,24,23,2B,2C,34,35,33,3C,3B,42) to notes 0..12.
REQ-014 SHALL map keys 1..5 (16,1E,26,25,2E) to ADSR_selector 0..4 on make; the value is held until the next selection.
REQ-015 SHALL implement FSM states IDLE, BRK (after F0), EXT (after E0), EXT_BRK (after E0 F0).
REQ-016 Transitions SHALL be: IDLE-F0->BRK; IDLE-E0->EXT; IDLE-other->IDLE as a make; BRK-any->IDLE as a break; EXT-F0->EXT_BRK; EXT-other->IDLE, ignored; EXT_BRK-any->IDLE, ignored.
REQ-017 SHALL drive all outputs from registers that update on the clk edge after the byte_valid cycle (1-cycle latency).
REQ-018 SHALL, on a note-key make, set note to its index and assert note_in, replacing any previously held note (last-key priority).
REQ-019 SHALL deassert note_in only on a break of the key currently in note; a break of any other note key SHALL change nothing.
REQ-020 SHALL treat typematic repeats (make of an already-held key) as no-ops with no output glitch.
REQ-021 SHALL assert octave/ADSR +/- outputs from make to break independently; X and Z held together SHALL assert both.
REQ-022 SHALL ignore unmapped codes in every state, apart from the state transition they cause.
REQ-023 SHALL, in BRK/EXT/EXT_BRK, return to IDLE with no output change when TIMEOUT_CYCLES elapse without byte_valid; the counter SHALL clear on every byte_valid and hold at zero in IDLE.
REQ-024 SHALL ignore byte_valid while reset is low.

Reset
REQ-025 SHALL, on reset low at a clk edge: state IDLE, timeout counter 0, note_in 0, note 0, ADSR_selector 0, all +/- outputs 0.
REQ-026 SHALL, on reset mid-sequence (e.g. after F0), discard the pending prefix; the next byte is decoded as a make.

Structure
REQ-027 SHALL place scan-code constants, the FSM state encoding and NOTE_MAX=12 in shared package synth_kbd_pkg.
REQ-028 SHALL contain one combinational sub-module, ps2_note_map (byte in -> hit flag + 4-bit note index).

Verification
REQ-029 Bytes 1C, F0 1C -> note=0 and note_in=1 one cycle after 1C; note_in=0 one cycle after the final 1C.
REQ-030 Bytes 1C, 42, F0 1C -> note=12 and note_in stays 1; then F0 42 -> note_in=0.
REQ-031 Bytes 22, 22, 22, F0 22 -> octave_plus_plus high from first 22 through final 22 with no glitch; others stay 0.
REQ-032 Bytes 26, 55, F0 55 -> ADSR_selector=2; ADSR_plus_plus high only between 55 and the final 55.
REQ-033 Byte F0, then no byte for TIMEOUT_CYCLES, then 1C -> FSM back in IDLE; 1C decoded as make, note_in=1.
REQ-034 Bytes E0 F0 1C, and reset low after F0 then byte 1C -> E0-prefixed sequence gives no output change; after reset, 1C is a make, note_in=1.
